// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side buffer between the buart receiver and the CPU IO page.
// Each byte presented by buart is acknowledged with a single uart_rd pulse
// and stored in a small first-word-fall-through FIFO. This keeps input from
// being lost while firmware is busy elsewhere.
//
// Ports:
//   clk           system clock
//   reset_button  asynchronous, active-low reset
//   uart_valid    buart holds a received byte (held until acknowledged)
//   uart_data     buart received byte, stable while uart_valid
//   uart_rd       one-cycle acknowledge pulse to buart
//   pop           CPU read strobe; removes the head byte
//   flush         synchronous discard of all stored bytes
//   clr_overflow  synchronous clear of the overflow flag
//   rdata         head byte, 8'h00 when empty
//   empty         level == 0
//   full          level == 2**DEPTH_LOG2
//   level         number of stored bytes
//   overflow      sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_button,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_data,
    output logic                  uart_rd,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_overflow,
    output logic [7:0]            rdata,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        HOLDOFF
    } state_t;

    state_t state;
    state_t state_next;

    logic                  intake;
    logic                  eff_pop;
    logic                  write_ok;
    logic                  drop;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [7:0]            mem [DEPTH];

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // HOLDOFF covers the cycle in which buart still shows valid after
    // seeing rd, so the same byte is never taken twice.
    always_comb begin
        state_next = state;
        intake     = 1'b0;
        case (state)
            IDLE: begin
                if (uart_valid) begin
                    intake     = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gated by reset so the acknowledge drops immediately when reset asserts,
    // even if buart is still holding valid.
    assign uart_rd = intake & reset_button;

    // Flush overrides everything: a coincident pop is ignored and a
    // coincident intake is acknowledged but its byte is thrown away without
    // touching overflow. A pop frees a slot, so push+pop while full is legal.
    always_comb begin
        eff_pop  = pop & ~empty & ~flush;
        write_ok = intake & ~flush & (~full | eff_pop);
        drop     = intake & ~flush & full & ~eff_pop;
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr] <= uart_data;
        end
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (eff_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({write_ok, eff_pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // A new drop takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign rdata = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo: a table of single-cycle vectors for
// the basic handshake, pop, flush and underflow cases, followed by
// hand-written sequences for fill/overflow, pointer wrap and reset
// in the middle of a handshake.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_button;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_rd;
    logic       pop;
    logic       flush;
    logic       clr_overflow;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       pop;
        logic       flush;
        logic       clr;
        logic       exp_rd;
        logic [4:0] exp_level;
        logic       exp_empty;
        logic       exp_full;
        logic [7:0] exp_rdata;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [11];
    logic [7:0] model_q [$];

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .reset_button (reset_button),
        .uart_valid   (uart_valid),
        .uart_data    (uart_data),
        .uart_rd      (uart_rd),
        .pop          (pop),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .rdata        (rdata),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic v, logic [7:0] d, logic p, logic f, logic c,
                                logic erd, logic [4:0] elvl, logic eemp, logic efull,
                                logic [7:0] erdata, logic eovf);
        vec_t r;
        r.valid     = v;
        r.data      = d;
        r.pop       = p;
        r.flush     = f;
        r.clr       = c;
        r.exp_rd    = erd;
        r.exp_level = elvl;
        r.exp_empty = eemp;
        r.exp_full  = efull;
        r.exp_rdata = erdata;
        r.exp_ovf   = eovf;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational
    // acknowledge before the rising edge, then check registered state after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        uart_valid   = v.valid;
        uart_data    = v.data;
        pop          = v.pop;
        flush        = v.flush;
        clr_overflow = v.clr;
        #1;
        checkOutput($sformatf("vec%0d_uart_rd", idx), 32'(uart_rd), 32'(v.exp_rd));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d_level", idx), 32'(level), 32'(v.exp_level));
        checkOutput($sformatf("vec%0d_empty", idx), 32'(empty), 32'(v.exp_empty));
        checkOutput($sformatf("vec%0d_full", idx), 32'(full), 32'(v.exp_full));
        checkOutput($sformatf("vec%0d_rdata", idx), 32'(rdata), 32'(v.exp_rdata));
        checkOutput($sformatf("vec%0d_overflow", idx), 32'(overflow), 32'(v.exp_ovf));
    endtask

    // Behaves like buart: valid held through the acknowledge cycle and one
    // cycle after it, then dropped.
    task automatic sendByte(input logic [7:0] d, input logic pop_en,
                            input logic clr_en, input string tag);
        @(negedge clk);
        uart_valid   = 1'b1;
        uart_data    = d;
        pop          = pop_en;
        clr_overflow = clr_en;
        #1;
        checkOutput({tag, "_rd_pulse"}, 32'(uart_rd), 32'd1);
        @(negedge clk);
        pop          = 1'b0;
        clr_overflow = 1'b0;
        #1;
        checkOutput({tag, "_rd_holdoff"}, 32'(uart_rd), 32'd0);
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    task automatic popCheck(input logic [7:0] expected, input string tag);
        @(negedge clk);
        pop = 1'b1;
        #1;
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'(expected));
        @(posedge clk);
        #1;
        pop = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_button = 1'b0;
        uart_valid   = 1'b0;
        uart_data    = 8'h00;
        pop          = 1'b0;
        flush        = 1'b0;
        clr_overflow = 1'b0;

        vecs[0]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h41, 1'b0);
        vecs[1]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h41, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h41, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[5]  = mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h22, 1'b0);
        vecs[6]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h22, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[8]  = mk(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[9]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset state.
        #2;
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'h00);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_uart_rd", 32'(uart_rd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_button = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end
        @(negedge clk);
        uart_valid   = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        clr_overflow = 1'b0;

        // Fill to capacity, then a 17th byte is acknowledged but dropped.
        for (int i = 0; i < 16; i++) begin
            sendByte(8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        checkOutput("fill_level", 32'(level), 32'd16);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_overflow_clear", 32'(overflow), 32'd0);
        sendByte(8'hAA, 1'b0, 1'b0, "drop_aa");
        checkOutput("drop_level", 32'(level), 32'd16);
        checkOutput("drop_overflow", 32'(overflow), 32'd1);

        // Clear coinciding with another drop: set wins.
        sendByte(8'hBB, 1'b0, 1'b1, "drop_bb_clr");
        checkOutput("set_beats_clr", 32'(overflow), 32'd1);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        checkOutput("clr_alone", 32'(overflow), 32'd0);

        // Push and pop together while full: no overflow, 8'h55 lands last.
        sendByte(8'h55, 1'b1, 1'b0, "full_pushpop");
        checkOutput("pushpop_level", 32'(level), 32'd16);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            popCheck(8'(i), $sformatf("drain%0d", i));
        end
        popCheck(8'h55, "drain_55");
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_rdata", 32'(rdata), 32'h00);

        // Twenty bytes through a running queue so both pointers wrap.
        for (int i = 0; i < 20; i++) begin
            sendByte(8'h80 + 8'(i), 1'b0, 1'b0, $sformatf("wrap_in%0d", i));
            model_q.push_back(8'h80 + 8'(i));
            if (model_q.size() > 3) begin
                popCheck(model_q.pop_front(), $sformatf("wrap_out%0d", i));
            end
        end
        while (model_q.size() > 0) begin
            popCheck(model_q.pop_front(), "wrap_tail");
        end
        checkOutput("wrap_empty", 32'(empty), 32'd1);

        // Flush with a coincident pop at level 5.
        for (int i = 0; i < 5; i++) begin
            sendByte(8'h10 + 8'(i), 1'b0, 1'b0, $sformatf("lvl5_%0d", i));
        end
        checkOutput("lvl5_level", 32'(level), 32'd5);
        @(negedge clk);
        flush = 1'b1;
        pop   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        pop   = 1'b0;
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);

        // Reset while uart_rd is high, with overflow set beforehand.
        for (int i = 0; i < 17; i++) begin
            sendByte(8'hC0 + 8'(i), 1'b0, 1'b0, $sformatf("prerst%0d", i));
        end
        checkOutput("prerst_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        uart_valid = 1'b1;
        uart_data  = 8'h5A;
        #1;
        checkOutput("rst_pre_rd", 32'(uart_rd), 32'd1);
        #1;
        reset_button = 1'b0;
        #1;
        checkOutput("rst_async_rd", 32'(uart_rd), 32'd0);
        checkOutput("rst_async_level", 32'(level), 32'd0);
        checkOutput("rst_async_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_async_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset_button = 1'b1;
        #1;
        checkOutput("rst_release_rd", 32'(uart_rd), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rst_retake_level", 32'(level), 32'd1);
        checkOutput("rst_retake_rdata", 32'(rdata), 32'h5A);
        @(negedge clk);
        #1;
        checkOutput("rst_holdoff_rd", 32'(uart_rd), 32'd0);
        @(negedge clk);
        uart_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_final_level", 32'(level), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the buart receiver and the CPU IO page.
- Drains each byte the UART presents (valid/rd handshake) into a small FIFO, so firmware busy with VGA text updates does not lose input at 115200 baud.
- Exposes first-word-fall-through data, level and a sticky overflow flag for the UART status IO register.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).

Ports:
clk  input  1  system clock (50 MHz doubled clock).
reset_button  input  1  asynchronous, active-low reset.
uart_valid  input  1  buart holds a received byte; stays high until acknowledged.
uart_data  input  8  buart received byte, stable while uart_valid.
uart_rd  output  1  one-cycle acknowledge pulse to buart (its rd input).
pop  input  1  CPU read strobe for the data register; removes the head byte.
flush  input  1  synchronous discard of all stored bytes.
clr_overflow  input  1  synchronous clear of the overflow flag.
rdata  output  8  head byte; 8'h00 when empty.
empty  output  1  level == 0.
full  output  1  level == 2**DEPTH_LOG2.
level  output  DEPTH_LOG2+1  number of stored bytes.
overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset_button low, asynchronous): write pointer, read pointer and level = 0; overflow = 0; uart_rd = 0; FSM = IDLE. Storage contents are not reset. After reset: empty = 1, full = 0, rdata = 0.
- Pointers: DEPTH_LOG2 bits wide, wrapping modulo depth. Level is kept as a separate counter; full/empty are decoded from level only.
- Intake FSM, states IDLE and HOLDOFF:
  - IDLE, uart_valid = 1: assert uart_rd for exactly one cycle, go to HOLDOFF. In the same cycle either write uart_data at the write pointer and advance it, or, when full and no simultaneous pop, drop the byte and set overflow.
  - HOLDOFF: uart_rd = 0; unconditionally return to IDLE next cycle. This absorbs the one-cycle latency before buart drops valid, so no byte is taken twice.
  - IDLE, uart_valid = 0: stay in IDLE.
  - Consequence: at most one intake per 2 cycles, far faster than the UART byte rate.
- Pop: when pop = 1 and not empty, advance the read pointer. Pop while empty is ignored; no underflow and no pointer change.
- Push and pop in the same cycle:
  - Level unchanged.
  - Allowed even when full, because the pop frees the slot; overflow is not set.
  - When empty: the byte is written, the pop is ignored, and level becomes 1.
- rdata is combinational from storage at the read pointer, valid in the same cycle empty = 0 (FWFT). The CPU-side register buffers it alongside the read strobe.
- Flush: highest priority among synchronous controls.
  - Pointers and level go to 0; a coincident pop is ignored.
  - A coincident intake is still acknowledged (uart_rd pulses) but its byte is discarded.
  - Overflow is unaffected.
- Overflow: set on a dropped byte and held until clr_overflow or reset. Set and clear in the same cycle: set wins.
- Level arithmetic: +1 on accepted write, −1 on effective pop; it never exceeds depth and never wraps below 0.
- Reset mid-handshake: if reset asserts during HOLDOFF or while uart_rd is high, uart_rd drops immediately and the FSM restarts in IDLE. A byte still pending in buart is taken on the first IDLE cycle after reset release.

Test Plan:
- Reset, then uart_valid held with uart_data = 8'h41 (buart drops valid 1 cycle after rd) -> exactly one uart_rd pulse; next cycle empty = 0, level = 1, rdata = 8'h41; pop -> empty = 1, rdata = 8'h00.
- Push 16 bytes 8'h00..8'h0F, then a 17th byte 8'hAA -> full = 1, level = 16, uart_rd still pulses for 8'hAA, overflow = 1. Pop 16 times -> rdata sequence 00..0F, 8'hAA never appears.
- With full = 1, pop in the same cycle as intake of 8'h55 -> level stays 16, overflow stays 0, 8'h55 is read last.
- Fill 20 bytes through repeated push/pop (pointers wrap past 15) -> output order matches input order exactly.
- overflow = 1, assert clr_overflow together with a new dropped byte -> overflow remains 1; clr_overflow alone next cycle -> overflow = 0.
- Level 5, assert flush and pop together -> level = 0, empty = 1. Assert reset_button low mid-uart_rd pulse -> uart_rd = 0 asynchronously, level = 0, overflow = 0.
